ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameters SHALL be: DWIDTH, default 16, RAM word width (fixed at two bytes); AWIDTH, default 12, RAM address width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle command request; sampled only in IDLE.
REQ-005 mode  input  1  0 = load (bytes to RAM), 1 = dump (RAM to bytes); sampled with start.
REQ-006 base_addr  input  12  first RAM word address; sampled with start.
REQ-007 count  input  13  word count; 0 = no-op; values above 4096 clamp to 4096; sampled with start.
REQ-008 in_valid / in_data  input  1 / 8  byte stream in; ready/valid handshake.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_valid / out_data  output  1 / 8  byte stream out; ready/valid handshake.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 ram_load  output  1  RAM write enable, to the RAM load port.
REQ-013 ram_addr  output  12  RAM address.
REQ-014 ram_d  output  16  RAM write data.
REQ-015 ram_q  input  16  RAM read data; RAM registers it on the edge after ram_addr is presented.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at command completion.

Function
REQ-018 The FSM SHALL have states IDLE, LD_HI, LD_LO, LD_WR, RD_ADDR, RD_CAP, RD_HI, RD_LO, and DONE.
REQ-019 In IDLE, start=1 SHALL latch addr=base_addr and rem=min(count,4096), then go to DONE if rem=0, else to LD_HI (mode 0) or RD_ADDR (mode 1).
REQ-020 start while busy SHALL be ignored, with no effect on the latched command.
REQ-021 LD_HI SHALL assert in_ready; on in_valid it SHALL capture the high byte and go to LD_LO.
REQ-022 LD_LO SHALL assert in_ready; on in_valid it SHALL set ram_d={hi,in_data} and go to LD_WR.
REQ-023 LD_WR SHALL last exactly one cycle with ram_load=1 and ram_addr=addr.
REQ-024 After LD_WR, addr SHALL increment modulo 4096 (0xFFF to 0x000) and rem SHALL decrement; the FSM goes to DONE if rem reaches 0, else to LD_HI.
REQ-025 in_ready SHALL be 0 in all states other than LD_HI and LD_LO.
REQ-026 RD_ADDR SHALL drive ram_addr=addr with ram_load=0 for one cycle, then go to RD_CAP.
REQ-027 RD_CAP SHALL register ram_q into a 16-bit holding register, then go to RD_HI.
REQ-028 RD_HI SHALL present out_valid=1 and out_data=hold[15:8]; on out_ready it SHALL go to RD_LO.
REQ-029 RD_LO SHALL present out_valid=1 and out_data=hold[7:0].
REQ-030 On an out_ready handshake in RD_LO, addr SHALL increment modulo 4096, rem SHALL decrement, and the FSM goes to DONE if rem reaches 0, else to RD_ADDR.
REQ-031 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-032 Latency from the start cycle to the first out_valid SHALL be 3 cycles.
REQ-033 Each load word SHALL take 3 cycles minimum; each dump word SHALL take 4 cycles minimum.
REQ-034 DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-035 ram_load SHALL be 1 only in LD_WR.
REQ-036 ram_addr SHALL always equal the current addr register.

Reset
REQ-037 rst_n=0 SHALL immediately and asynchronously force: state IDLE, ram_load=0, in_ready=0, out_valid=0, busy=0, done=0, addr=0, rem=0, ram_d=0, out_data=0, hold=0.
REQ-038 Reset mid-command SHALL abort the command with no further RAM write, and no done pulse SHALL follow.

Verification
REQ-039 Load test: start, mode=0, base=0x000, count=2, bytes D0 00 30 10 -> mem[0]=0xD000, mem[1]=0x3010, exactly two ram_load pulses, done one cycle after the second write.
REQ-040 Dump test: mem[5..6]=0x500F,0x2010, mode=1, base=0x005, count=2, out_ready=1 -> bytes 50 0F 20 10, first out_valid 3 cycles after start.
REQ-041 Wrap test: load with base=0xFFF and count=2 -> writes to 0xFFF then 0x000.
REQ-042 Backpressure and count test: dump with out_ready toggling 1-of-3 cycles -> byte order and data unchanged; count=0 -> done with no RAM access; count=5000 -> 4096 words.
REQ-043 Reset test: rst_n pulsed low between LD_HI and LD_LO -> ram_load never asserts, block in IDLE, busy=0; start during busy -> ignored.

Source files
------------

// File: rtl/ram_loader.sv
// ram_loader: moves 16-bit words between a byte stream and a single-port RAM.
// Load packs byte pairs (high first) into RAM words; dump unpacks RAM words into byte pairs.
`default_nettype none

module ram_loader #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              ram_load,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q,
  output logic              busy,
  output logic              done
);

  localparam logic [AWIDTH:0] MAX_WORDS = {1'b1, {AWIDTH{1'b0}}};

  typedef enum logic [3:0] {
    IDLE, LD_HI, LD_LO, LD_WR, RD_ADDR, RD_CAP, RD_HI, RD_LO, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] addr;
  logic [AWIDTH:0]   rem;
  logic [AWIDTH:0]   count_clamped;
  logic [7:0]        hi_byte;
  logic [DWIDTH-1:0] hold;
  logic              last_word;

  assign count_clamped = (count > MAX_WORDS) ? MAX_WORDS : count;
  assign last_word     = (rem == {{AWIDTH{1'b0}}, 1'b1});
  assign ram_addr      = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      rem     <= '0;
      hi_byte <= '0;
      ram_d   <= '0;
      hold    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            addr <= base_addr;
            rem  <= count_clamped;
          end
        end
        LD_HI: if (in_valid) hi_byte <= in_data;
        LD_LO: if (in_valid) ram_d <= {hi_byte, in_data};
        LD_WR: begin
          addr <= addr + 1'b1;
          rem  <= rem - 1'b1;
        end
        // ram_q reflects addr presented during RD_ADDR
        RD_CAP: hold <= ram_q;
        RD_LO: begin
          if (out_ready) begin
            addr <= addr + 1'b1;
            rem  <= rem - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    ram_load  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          if (count_clamped == '0) state_nxt = DONE;
          else if (mode)           state_nxt = RD_ADDR;
          else                     state_nxt = LD_HI;
        end
      end
      LD_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LD_LO;
      end
      LD_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LD_WR;
      end
      LD_WR: begin
        ram_load  = 1'b1;
        state_nxt = last_word ? DONE : LD_HI;
      end
      RD_ADDR: state_nxt = RD_CAP;
      RD_CAP:  state_nxt = RD_HI;
      RD_HI: begin
        out_valid = 1'b1;
        out_data  = hold[DWIDTH-1:DWIDTH/2];
        if (out_ready) state_nxt = RD_LO;
      end
      RD_LO: begin
        out_valid = 1'b1;
        out_data  = hold[DWIDTH/2-1:0];
        if (out_ready) state_nxt = last_word ? DONE : RD_ADDR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed + randomized checks of ram_loader against a word/byte-level model.
`default_nettype none

module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] count = '0;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        ram_load;
  logic [11:0] ram_addr;
  logic [15:0] ram_d;
  logic [15:0] ram_q;
  logic        busy;
  logic        done;

  ram_loader #(.DWIDTH(16), .AWIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_load(ram_load), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural RAM with registered read; preload/fill hooks driven by the main sequence.
  logic [15:0] ram [4096];
  logic [15:0] ref_mem [4096];
  logic        fill = 1'b0;
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 16'(i * 16'h9E37 + 16'h1234);
    end else begin
      if (pl_en) ram[pl_addr] <= pl_data;
      if (ram_load) ram[ram_addr] <= ram_d;
    end
    ram_q <= ram[ram_addr];
  end

  // Byte source
  logic [7:0] src_q[$];
  int         src_idx = 0;
  bit         gaps = 1'b1;

  initial begin
    bit hs;
    in_valid = 1'b0;
    in_data  = 8'h00;
    forever begin
      @(posedge clk);
      hs = in_valid && in_ready;
      #1;
      if (hs) src_idx++;
      if (src_idx < src_q.size() && (!gaps || $urandom_range(3) != 0)) begin
        in_valid = 1'b1;
        in_data  = src_q[src_idx];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
  end

  // Byte sink backpressure: 0 = always ready, 1 = ready 1-of-3, 2 = random
  int bp_mode = 0;
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 3;
      case (bp_mode)
        1:       out_ready = (ph == 0);
        2:       out_ready = 1'($urandom);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Observation of DUT activity at each rising edge
  logic [7:0]  out_q[$];
  logic [11:0] wr_addr_q[$];
  int cyc = 0, start_cyc = 0, last_lat = -1, last_wr_cyc = -1, done_cyc = -1;
  int n_wr = 0, n_done = 0;
  bit armed = 1'b0, stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (start && !busy) begin
        start_cyc = cyc;
        armed = 1'b1;
      end
      if (out_valid && armed) begin
        last_lat = cyc - start_cyc;
        armed = 1'b0;
      end
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (ram_load) begin
        n_wr++;
        last_wr_cyc = cyc;
        wr_addr_q.push_back(ram_addr);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (stall_prev) check("out_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, stall_data});
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_prev = 1'b0;
      armed = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
  endtask

  function automatic int words_of(input logic [12:0] c);
    return (c > 13'd4096) ? 4096 : int'(c);
  endfunction

  // Issue one command; optionally fire a spurious start 'poke' cycles into it.
  task automatic run_cmd(input logic m, input logic [11:0] b, input logic [12:0] c,
                         input int limit, input int poke);
    int n;
    mode = m; base_addr = b; count = c; start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = 12'($urandom); count = 13'($urandom);
    check("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < limit) begin
      if (n == poke) begin
        start = 1'b1; mode = ~m; base_addr = 12'h200; count = 13'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    tick();
    check("idle_after_done", {busy, done}, 2'b00);
  endtask

  task automatic do_load(input logic [11:0] b, input logic [12:0] c, input int limit);
    int words, s0, w0, a0, bad;
    words = words_of(c);
    s0 = src_q.size() - 2 * words;
    w0 = n_wr; a0 = wr_addr_q.size();
    run_cmd(1'b0, b, c, limit, -1);
    for (int i = 0; i < words; i++)
      ref_mem[(int'(b) + i) % 4096] = {src_q[s0 + 2 * i], src_q[s0 + 2 * i + 1]};
    check("load_write_count", n_wr - w0, words);
    bad = 0;
    for (int i = 0; i < words && a0 + i < wr_addr_q.size(); i++)
      if (int'(wr_addr_q[a0 + i]) != (int'(b) + i) % 4096) bad++;
    check("load_addr_seq", bad, 0);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("ram_contents", bad, 0);
  endtask

  task automatic do_dump(input logic [11:0] b, input logic [12:0] c, input int limit, input int poke);
    int words, o0, w0, bad;
    logic [15:0] w;
    words = words_of(c);
    o0 = out_q.size(); w0 = n_wr;
    run_cmd(1'b1, b, c, limit, poke);
    check("dump_byte_count", out_q.size() - o0, 2 * words);
    check("dump_no_write", n_wr - w0, 0);
    bad = 0;
    for (int i = 0; i < words && o0 + 2 * i + 1 < out_q.size(); i++) begin
      w = ref_mem[(int'(b) + i) % 4096];
      if (out_q[o0 + 2 * i] !== w[15:8] || out_q[o0 + 2 * i + 1] !== w[7:0]) bad++;
    end
    check("dump_bytes", bad, 0);
    if (words > 0) check("dump_latency", last_lat, 3);
  endtask

  initial begin
    int w0, d0, o0, n;
    logic [11:0] rb;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'(i * 16'h9E37 + 16'h1234);
    fill = 1'b1;
    tick(); tick();
    fill = 1'b0;
    tick();

    // Reset state
    check("rst_ctrl", {busy, done, in_ready, out_valid, ram_load}, 5'b0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_d", ram_d, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick(); tick();

    // Directed load: D0 00 30 10 at 0x000
    src_q.push_back(8'hD0); src_q.push_back(8'h00);
    src_q.push_back(8'h30); src_q.push_back(8'h10);
    d0 = n_done;
    do_load(12'h000, 13'd2, 100);
    check("load_mem0", ram[0], 16'hD000);
    check("load_mem1", ram[1], 16'h3010);
    check("done_after_write", done_cyc - last_wr_cyc, 1);
    check("load_one_done", n_done - d0, 1);

    // Directed dump of mem[5..6]
    pl_en = 1'b1; pl_addr = 12'h005; pl_data = 16'h500F; tick();
    pl_addr = 12'h006; pl_data = 16'h2010; tick();
    pl_en = 1'b0;
    ref_mem[5] = 16'h500F; ref_mem[6] = 16'h2010;
    o0 = out_q.size();
    do_dump(12'h005, 13'd2, 100, -1);
    check("dump_b0", out_q[o0], 8'h50);
    check("dump_b3", out_q[o0 + 3], 8'h10);

    // Address wrap
    push_rand(4);
    w0 = wr_addr_q.size();
    do_load(12'hFFF, 13'd2, 100);
    check("wrap_first", wr_addr_q[w0], 12'hFFF);
    check("wrap_second", wr_addr_q[w0 + 1], 12'h000);

    // Backpressure 1-of-3, across the wrap point
    bp_mode = 1;
    do_dump(12'hFFD, 13'd6, 200, -1);
    bp_mode = 0;

    // count = 0 in both modes
    o0 = out_q.size(); d0 = n_done;
    do_load(12'($urandom), 13'd0, 10);
    do_dump(12'($urandom), 13'd0, 10, -1);
    check("zero_count_done", n_done - d0, 2);

    // count above 4096 clamps
    gaps = 1'b0;
    push_rand(8192);
    do_load(12'($urandom), 13'd5000, 20000);
    gaps = 1'b1;
    do_dump(12'($urandom), 13'd40, 400, -1);

    // Random mixed commands with random backpressure and input gaps
    bp_mode = 2;
    for (int k = 0; k < 6; k++) begin
      rb = ($urandom_range(1) == 1) ? 12'hFFE : 12'($urandom);
      n = $urandom_range(6, 1);
      if ($urandom_range(1) == 1) do_dump(rb, 13'(n), 200, -1);
      else begin
        push_rand(2 * n);
        do_load(rb, 13'(n), 200);
      end
    end
    bp_mode = 0;

    // Start while busy must not disturb the running dump
    w0 = n_wr; d0 = n_done;
    do_dump(12'h100, 13'd3, 100, 2);
    check("busy_start_no_write", n_wr - w0, 0);
    check("busy_start_one_done", n_done - d0, 1);

    // Reset between LD_HI and LD_LO
    src_q.push_back(8'hA5);
    w0 = n_wr; d0 = n_done;
    mode = 1'b0; base_addr = 12'h300; count = 13'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (src_idx < src_q.size() && n < 50) begin
      tick();
      n++;
    end
    #2;
    check("in_ld_lo", {busy, in_ready}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_rst", {busy, in_ready, ram_load, done}, 4'b0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("rst_no_write", n_wr - w0, 0);
    check("rst_no_done", n_done - d0, 0);
    check("rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
